pll_clkdiv_bank: RTL and testbench

PLL_CLKDIV_BANK -- requirements
Module: pll_clkdiv_bank

---
 rtl/pll_clkdiv_pkg.sv | 18 +
 rtl/pll_clkdiv_sync2.sv | 24 ++
 rtl/pll_clkdiv_bank.sv | 159 +++++++++++++++
 tb/tb_pll_clkdiv_bank.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pll_clkdiv_pkg.sv
// Shared types and helpers for the PLL clock-divider bank.
package pll_clkdiv_pkg;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    SETTLE    = 2'd1,
    RUN       = 2'd2,
    LOST      = 2'd3
  } state_e;

  localparam int LOL_CNT_W = 8;

  // Channel-select width; a single channel still needs one select bit.
  function automatic int ch_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pll_clkdiv_sync2.sv
// Two-flop synchronizer for the asynchronous PLL lock flag, cleared to 0 on reset.
module pll_clkdiv_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_meta <= 1'b0;
      r_q    <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_q    <= r_meta;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/pll_clkdiv_bank.sv
// Lock-qualified clock-enable divider bank with glitch-free live reconfiguration.
// Optional loss-of-lock event counter built only when PLL_CLKDIV_LOL_COUNT_EN is defined.
//
// state     | meaning
// WAIT_LOCK | waiting for synchronized lock
// SETTLE    | counting consecutive locked cycles
// RUN       | lock stable, strobes active, ready high
// LOST      | one-cycle loss-of-lock marker
module pll_clkdiv_bank
  import pll_clkdiv_pkg::*;
#(
  parameter int NUM_CH      = 2,
  parameter int DIV_W       = 8,
  parameter int SETTLE_CYC  = 1024,
  parameter int DEFAULT_DIV = 5
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       pll_lock,
  input  logic                       cfg_we,
  input  logic [ch_w(NUM_CH)-1:0]    cfg_ch,
  input  logic [DIV_W-1:0]           cfg_div,
  input  logic [DIV_W-1:0]           cfg_phase,
  output logic [NUM_CH-1:0]          ce,
  output logic                       ready,
  output logic [LOL_CNT_W-1:0]       lol_cnt
);

  localparam int CH_W  = ch_w(NUM_CH);
  localparam int SET_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [SET_W-1:0] SET_LOAD = SET_W'(SETTLE_CYC - 1);
  localparam logic [DIV_W-1:0] DEF_DIV  = DIV_W'(DEFAULT_DIV);
  localparam logic [DIV_W-1:0] DEF_LAST = (DEFAULT_DIV > 1) ? DIV_W'(DEFAULT_DIV - 1) : '0;

  logic             w_lock_s;
  state_e           r_state;
  logic [SET_W-1:0] r_settle_cnt;
  logic             r_ready;
  logic             w_run;
  logic             w_run_entry;

  pll_clkdiv_sync2 u_sync (
    .clk (clk),
    .rst (rst),
    .i_d (pll_lock),
    .o_q (w_lock_s)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= WAIT_LOCK;
      r_settle_cnt <= '0;
      r_ready      <= 1'b0;
    end else begin
      r_ready <= 1'b0;
      case (r_state)
        WAIT_LOCK: begin
          if (w_lock_s) begin
            r_state      <= SETTLE;
            r_settle_cnt <= SET_LOAD;
          end
        end
        SETTLE: begin
          if (!w_lock_s) begin
            r_state <= WAIT_LOCK;
          end else if (r_settle_cnt == '0) begin
            r_state <= RUN;
            r_ready <= 1'b1;
          end else begin
            r_settle_cnt <= r_settle_cnt - 1'b1;
          end
        end
        RUN: begin
          if (!w_lock_s) begin
            r_state <= LOST;
          end else begin
            r_ready <= 1'b1;
          end
        end
        LOST:    r_state <= WAIT_LOCK;
        default: r_state <= WAIT_LOCK;
      endcase
    end
  end

  assign ready       = r_ready;
  assign w_run       = (r_state == RUN);
  assign w_run_entry = (r_state == SETTLE) && w_lock_s && (r_settle_cnt == '0);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    localparam logic [CH_W-1:0] IDX = CH_W'(i);

    logic [DIV_W-1:0] r_sh_div;
    logic [DIV_W-1:0] r_sh_phase;
    logic [DIV_W-1:0] r_last;
    logic [DIV_W-1:0] r_cnt;
    logic             r_pend;
    logic             w_wr;
    logic             w_tc;
    logic [DIV_W-1:0] w_new_div;
    logic [DIV_W-1:0] w_new_phase;
    logic [DIV_W-1:0] w_new_last;
    logic [DIV_W-1:0] w_new_start;

    // A write landing on the boundary cycle bypasses the shadow so it takes effect there.
    assign w_wr        = cfg_we && (cfg_ch == IDX);
    assign w_new_div   = w_wr ? cfg_div : r_sh_div;
    assign w_new_phase = w_wr ? cfg_phase : r_sh_phase;
    assign w_new_last  = (w_new_div == '0) ? '0 : w_new_div - 1'b1;
    assign w_new_start = (w_new_phase > w_new_last) ? w_new_last : w_new_phase;
    assign w_tc        = (r_cnt == r_last);

    always_ff @(posedge clk) begin
      if (rst) begin
        r_sh_div   <= DEF_DIV;
        r_sh_phase <= '0;
        r_last     <= DEF_LAST;
        r_cnt      <= '0;
        r_pend     <= 1'b0;
      end else begin
        if (w_wr) begin
          r_sh_div   <= cfg_div;
          r_sh_phase <= cfg_phase;
        end
        if (w_run_entry || (w_run && w_tc && (r_pend || w_wr))) begin
          r_last <= w_new_last;
          r_cnt  <= w_new_start;
          r_pend <= 1'b0;
        end else if (w_run) begin
          r_cnt  <= w_tc ? '0 : r_cnt + 1'b1;
          r_pend <= r_pend | w_wr;
        end else begin
          r_last <= w_new_last;
          r_cnt  <= '0;
          r_pend <= 1'b0;
        end
      end
    end

    assign ce[i] = w_run && w_tc;
  end

`ifdef PLL_CLKDIV_LOL_COUNT_EN
  logic [LOL_CNT_W-1:0] r_lol_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_lol_cnt <= '0;
    end else if (w_run && !w_lock_s && (r_lol_cnt != '1)) begin
      r_lol_cnt <= r_lol_cnt + 1'b1;
    end
  end

  assign lol_cnt = r_lol_cnt;
`else
  assign lol_cnt = '0;
`endif

endmodule

// File: tb/tb_pll_clkdiv_bank.sv
// Scoreboard bench for pll_clkdiv_bank: a strobe-schedule reference model predicts each
// cycle's outputs; a negedge monitor pops and compares them.
module tb_pll_clkdiv_bank;

  localparam int NUM_CH  = 3;
  localparam int DIV_W   = 8;
  localparam int SETTLE  = 16;
  localparam int DEF_DIV = 5;
  localparam int CH_W    = 2;
  localparam int MAXCYC  = 30000;
`ifdef PLL_CLKDIV_LOL_COUNT_EN
  localparam bit LOL_EN = 1'b1;
`else
  localparam bit LOL_EN = 1'b0;
`endif

  localparam int M_WAIT = 0, M_SETTLE = 1, M_RUN = 2, M_LOST = 3;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              pll_lock = 1'b0;
  logic              cfg_we = 1'b0;
  logic [CH_W-1:0]   cfg_ch = '0;
  logic [DIV_W-1:0]  cfg_div = '0;
  logic [DIV_W-1:0]  cfg_phase = '0;
  logic [NUM_CH-1:0] ce_o;
  logic              ready_o;
  logic [7:0]        lol_o;

  pll_clkdiv_bank #(
    .NUM_CH      (NUM_CH),
    .DIV_W       (DIV_W),
    .SETTLE_CYC  (SETTLE),
    .DEFAULT_DIV (DEF_DIV)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .pll_lock  (pll_lock),
    .cfg_we    (cfg_we),
    .cfg_ch    (cfg_ch),
    .cfg_div   (cfg_div),
    .cfg_phase (cfg_phase),
    .ce        (ce_o),
    .ready     (ready_o),
    .lol_cnt   (lol_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int                cyc;
    logic              rdy;
    logic [NUM_CH-1:0] ce;
    logic [7:0]        lol;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // reference model state
  bit pl[MAXCYC];
  bit rs[MAXCYC];
  int m_st = M_WAIT;
  int m_good = 0;
  int m_lol = 0;
  int sd[NUM_CH];
  int sp[NUM_CH];
  int ns[NUM_CH];
  int per[NUM_CH];
  bit pend[NUM_CH];

  // observation log written by the monitor
  int ready_rise = -1000;
  int first_ce[NUM_CH];
  int ce0_hist[$];
  logic prev_ready = 1'b0;

  task automatic model_step(input int c, input bit r, input bit l, input bit we,
                            input int ch, input int dv, input int ph);
    bit   ls, wr_ok, entering, hit;
    int   prev, nd, np, p, st;
    exp_t e;
    pl[c] = l;
    rs[c] = r;
    ls = (c >= 2) && pl[c-2] && !rs[c-2] && !rs[c-1];
    wr_ok = we && !r && (ch < NUM_CH);
    if (r) begin
      m_st = M_WAIT; m_good = 0; m_lol = 0;
      for (int i = 0; i < NUM_CH; i++) begin
        sd[i] = DEF_DIV; sp[i] = 0; pend[i] = 1'b0;
      end
    end else begin
      prev = m_st;
      case (m_st)
        M_WAIT:   if (ls) begin m_st = M_SETTLE; m_good = 0; end
        M_SETTLE: if (!ls) m_st = M_WAIT;
                  else begin m_good++; if (m_good == SETTLE) m_st = M_RUN; end
        M_RUN:    if (!ls) begin m_st = M_LOST; if (m_lol < 255) m_lol++; end
        default:  m_st = M_WAIT;
      endcase
      entering = (prev == M_SETTLE) && (m_st == M_RUN);
      for (int i = 0; i < NUM_CH; i++) begin
        hit = wr_ok && (ch == i);
        nd = hit ? dv : sd[i];
        np = hit ? ph : sp[i];
        p  = (nd == 0) ? 1 : nd;
        st = (np > p - 1) ? p - 1 : np;
        if (entering) begin
          per[i] = p;
          ns[i] = c + 1 + (p - 1 - st);
          pend[i] = 1'b0;
        end else if (prev == M_RUN) begin
          if (ns[i] == c) begin
            if (pend[i] || hit) begin
              per[i] = p;
              ns[i] = c + 1 + (p - 1 - st);
              pend[i] = 1'b0;
            end else begin
              ns[i] = c + per[i];
            end
          end else if (hit) begin
            pend[i] = 1'b1;
          end
        end else begin
          pend[i] = 1'b0;
        end
        if (hit) begin sd[i] = dv; sp[i] = ph; end
      end
    end
    e.cyc = c + 1;
    e.rdy = (m_st == M_RUN);
    for (int i = 0; i < NUM_CH; i++) e.ce[i] = e.rdy && (ns[i] == c + 1);
    e.lol = LOL_EN ? 8'(m_lol) : 8'd0;
    exp_q.push_back(e);
  endtask

  task automatic step(input bit r, input bit l, input bit we, input int ch,
                      input int dv, input int ph);
    rst = r; pll_lock = l; cfg_we = we;
    cfg_ch = ch[CH_W-1:0]; cfg_div = dv[DIV_W-1:0]; cfg_phase = ph[DIV_W-1:0];
    model_step(cyc, r, l, we, ch, dv, ph);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input bit l);
    for (int k = 0; k < n; k++) step(1'b0, l, 1'b0, 0, 0, 0);
  endtask

  task automatic check_int(input string name, input int got, input int want);
    n_cmp++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, got, want);
    end
  endtask

  task automatic check_win(input string name, input int got, input int lo, input int hi);
    n_cmp++;
    if (got < lo || got > hi) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, got, lo, hi);
    end
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    exp_t e;
    while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
      e = exp_q.pop_front();
      n_cmp++;
      if (e.cyc != cyc || ready_o !== e.rdy || ce_o !== e.ce || lol_o !== e.lol) begin
        n_bad++;
        $display("FAIL outputs@cyc%0d: got ready=%b ce=%b lol=%0d, expected ready=%b ce=%b lol=%0d (slot %0d)",
                 cyc, ready_o, ce_o, lol_o, e.rdy, e.ce, e.lol, e.cyc);
      end
    end
    if (ready_o === 1'b1 && prev_ready !== 1'b1) begin
      ready_rise = cyc;
      for (int i = 0; i < NUM_CH; i++) first_ce[i] = -1;
    end
    if (ready_o === 1'b1)
      for (int i = 0; i < NUM_CH; i++)
        if (ce_o[i] === 1'b1 && first_ce[i] < 0) first_ce[i] = cyc;
    if (ce_o[0] === 1'b1) ce0_hist.push_back(cyc);
    prev_ready = ready_o;
  end

  initial begin
    int lock_cyc, last_pre, mg, g, low_left;
    bit r, l, we;
    for (int i = 0; i < NUM_CH; i++) first_ce[i] = -1;
    @(posedge clk);
    #1;

    // reset, then configure ch0/ch1 before lock
    for (int k = 0; k < 3; k++) step(1'b1, 1'b0, 1'b1, 0, 9, 9);
    step(1'b0, 1'b0, 1'b1, 0, 4, 0);
    step(1'b0, 1'b0, 1'b1, 1, 4, 2);
    idle(5, 1'b0);

    // lock-up
    lock_cyc = cyc;
    idle(45, 1'b1);
    check_win("lockup_ready_latency", ready_rise - lock_cyc, SETTLE + 1, SETTLE + 3);
    check_int("ch0_first_strobe", first_ce[0] - ready_rise, 3);
    check_int("ch1_first_strobe", first_ce[1] - ready_rise, 1);
    check_int("ch2_default_first", first_ce[2] - ready_rise, DEF_DIV - 1);

    // live reconfiguration 4 -> 5 -> 3 on ch0
    step(1'b0, 1'b1, 1'b1, 0, 5, 0);
    idle(13, 1'b1);
    last_pre = (ce0_hist.size() > 0) ? ce0_hist[$] : -1000;
    ce0_hist.delete();
    step(1'b0, 1'b1, 1'b1, 0, 3, 0);
    idle(30, 1'b1);
    check_int("reconf_period_completes", (ce0_hist.size() > 0) ? ce0_hist[0] - last_pre : -1, 5);
    mg = 1000;
    for (int k = 1; k < ce0_hist.size(); k++) begin
      g = ce0_hist[k] - ce0_hist[k-1];
      if (g < mg) mg = g;
    end
    check_int("reconf_min_gap", mg, 3);

    // double write (last wins), out-of-range write
    step(1'b0, 1'b1, 1'b1, 1, 7, 0);
    step(1'b0, 1'b1, 1'b1, 1, 2, 1);
    step(1'b0, 1'b1, 1'b1, 3, 1, 0);
    idle(20, 1'b1);

    // loss of lock for 4 cycles
    idle(4, 1'b0);
    idle(45, 1'b1);

    // reset mid-RUN, then degenerate values
    step(1'b1, 1'b1, 1'b0, 0, 0, 0);
    step(1'b1, 1'b1, 1'b0, 0, 0, 0);
    step(1'b0, 1'b1, 1'b1, 1, 0, 0);
    step(1'b0, 1'b1, 1'b1, 2, 3, 9);
    idle(40, 1'b1);
    check_int("div3_phase9_strobe_on_entry", first_ce[2] - ready_rise, 0);
    check_int("div0_strobe_on_entry", first_ce[1] - ready_rise, 0);

    // repeated loss of lock (drives the counter to saturation)
    for (int k = 0; k < 260; k++) begin
      idle(3, 1'b0);
      idle(24, 1'b1);
    end

    // randomized traffic
    low_left = 0;
    for (int k = 0; k < 3000; k++) begin
      r = ($urandom_range(0, 999) == 0);
      if (low_left > 0) begin
        l = 1'b0;
        low_left--;
      end else begin
        l = 1'b1;
        if ($urandom_range(0, 149) == 0) low_left = $urandom_range(1, 5);
      end
      we = ($urandom_range(0, 5) == 0);
      step(r, l, we, $urandom_range(0, 3),
           ($urandom_range(0, 3) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 7),
           $urandom_range(0, 9));
    end
    idle(2, 1'b1);

    @(negedge clk);
    #1;
    check_int("scoreboard_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
